// File: rtl/preg_free_list_if.sv
// Rename/commit side bundle for the physical-register free list.
// The master (rename + commit) drives requests; the slave (free list) answers.
interface preg_free_list_if #(
    parameter int NUM_PREGS   = 64,
    parameter int NUM_AREGS   = 32,
    parameter int ALLOC_WIDTH = 2,
    parameter int FREE_WIDTH  = 2
);
    localparam int D    = NUM_PREGS - NUM_AREGS;
    localparam int PW   = $clog2(NUM_PREGS);
    localparam int CW   = $clog2(ALLOC_WIDTH + 1);
    localparam int PTRW = $clog2(D) + 1;

    logic [CW-1:0]                    alloc_cnt;
    logic                             alloc_ready;
    logic [ALLOC_WIDTH-1:0][PW-1:0]   alloc_preg;
    logic [FREE_WIDTH-1:0]            free_vld;
    logic [FREE_WIDTH-1:0][PW-1:0]    free_preg;
    logic [CW-1:0]                    retire_cnt;
    logic                             flush;
    logic [PTRW-1:0]                  free_cnt;
    logic                             overflow_err;

    modport master (
        output alloc_cnt, free_vld, free_preg, retire_cnt, flush,
        input  alloc_ready, alloc_preg, free_cnt, overflow_err
    );

    modport slave (
        input  alloc_cnt, free_vld, free_preg, retire_cnt, flush,
        output alloc_ready, alloc_preg, free_cnt, overflow_err
    );
endinterface

// File: rtl/preg_free_list.sv
// Circular free list of physical registers with speculative head, retired
// (architectural) head and tail pointers; flush rewinds head to the retired head.
module preg_free_list #(
    parameter int NUM_PREGS   = 64,
    parameter int NUM_AREGS   = 32,
    parameter int ALLOC_WIDTH = 2,
    parameter int FREE_WIDTH  = 2
) (
    input logic              clk,
    input logic              rst,
    preg_free_list_if.slave  fl_if
);
    localparam int D    = NUM_PREGS - NUM_AREGS;
    localparam int PW   = $clog2(NUM_PREGS);
    localparam int IW   = $clog2(D);
    localparam int PTRW = IW + 1;

    typedef logic [PTRW-1:0] ptr_t;
    typedef logic [PTRW:0]   wide_t;

    logic [PW-1:0] fl_q [D];
    logic [PW-1:0] fl_d [D];
    ptr_t head_q, head_d;
    ptr_t arch_head_q, arch_head_d;
    ptr_t tail_q, tail_d;
    logic ovf_q, ovf_d;

    ptr_t free_cnt;
    ptr_t spec_cnt;
    ptr_t retire_ext;
    ptr_t alloc_ext;
    ptr_t free_pop;
    ptr_t room_used;
    logic alloc_ready;
    logic alloc_fire;
    logic retire_ovf;
    logic free_ovf;

    function automatic logic [IW-1:0] slot(input ptr_t base, input int unsigned off);
        ptr_t p;
        p = base + ptr_t'(off);
        return p[IW-1:0];
    endfunction

    assign free_cnt    = tail_q - head_q;
    assign spec_cnt    = head_q - arch_head_q;
    assign alloc_ready = free_cnt >= ptr_t'(ALLOC_WIDTH);
    assign retire_ext  = ptr_t'(fl_if.retire_cnt);
    assign alloc_ext   = ptr_t'(fl_if.alloc_cnt);
    assign alloc_fire  = alloc_ready && (fl_if.alloc_cnt != '0) && !fl_if.flush;

    // A retire claiming more than is outstanding is flagged and ignored so the
    // pointers never cross.
    assign retire_ovf  = retire_ext > spec_cnt;
    assign arch_head_d = retire_ovf ? arch_head_q : arch_head_q + retire_ext;

    // Capacity is measured against the post-retire head: the PREG retiring this
    // cycle leaves the list, which is what makes room for its predecessor.
    assign room_used   = tail_q - arch_head_d;
    assign free_ovf    = ({1'b0, room_used} + {1'b0, free_pop}) > wide_t'(D);

    assign fl_if.alloc_ready  = alloc_ready;
    assign fl_if.free_cnt     = free_cnt;
    assign fl_if.overflow_err = ovf_q;

    always_comb begin
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            fl_if.alloc_preg[k] = fl_q[slot(head_q, k)];
        end
    end

    // NOTE: every variable written in this block gets a default first, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        int unsigned rank;
        fl_d     = fl_q;
        free_pop = '0;
        rank     = 0;
        for (int k = 0; k < FREE_WIDTH; k++) begin
            free_pop = free_pop + ptr_t'(fl_if.free_vld[k]);
        end
        // Valid lanes pack at tail in lane order; an overflowing batch is dropped whole.
        for (int k = 0; k < FREE_WIDTH; k++) begin
            if (fl_if.free_vld[k] && !free_ovf) begin
                fl_d[slot(tail_q, rank)] = fl_if.free_preg[k];
                rank = rank + 1;
            end
        end
    end

    always_comb begin
        head_d = head_q;
        if (fl_if.flush) begin
            head_d = arch_head_d;
        end else if (alloc_fire) begin
            head_d = head_q + alloc_ext;
        end
        tail_d = free_ovf ? tail_q : tail_q + free_pop;
        ovf_d  = ovf_q | free_ovf | retire_ovf;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            arch_head_q <= '0;
            tail_q      <= ptr_t'(D);
            ovf_q       <= 1'b0;
            // NOTE: the storage is reset on purpose: its reset contents are the
            // initial free list (every PREG not mapped by an AREG).
            for (int i = 0; i < D; i++) begin
                fl_q[i] <= PW'(NUM_AREGS + i);
            end
        end else begin
            head_q      <= head_d;
            arch_head_q <= arch_head_d;
            tail_q      <= tail_d;
            ovf_q       <= ovf_d;
            fl_q        <= fl_d;
        end
    end
endmodule

// File: tb/tb_preg_free_list.sv
// Self-checking bench for preg_free_list: directed scenarios plus a randomized
// run against a queue-based ownership model.
module tb_preg_free_list;
    localparam int NUM_PREGS = 64;
    localparam int NUM_AREGS = 32;
    localparam int D         = NUM_PREGS - NUM_AREGS;

    typedef struct {
        int areg;
        int newp;
        int oldp;
    } spec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_q[$];

    always #5 clk = ~clk;

    preg_free_list_if #(.NUM_PREGS(NUM_PREGS), .NUM_AREGS(NUM_AREGS),
                        .ALLOC_WIDTH(2), .FREE_WIDTH(2)) bus ();

    preg_free_list #(.NUM_PREGS(NUM_PREGS), .NUM_AREGS(NUM_AREGS),
                     .ALLOC_WIDTH(2), .FREE_WIDTH(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .fl_if (bus)
    );

    task automatic drive(input int ac, input logic [1:0] fv, input int p0, input int p1,
                         input int rc, input logic fl);
        bus.alloc_cnt    = 2'(ac);
        bus.free_vld     = fv;
        bus.free_preg[0] = 6'(p0);
        bus.free_preg[1] = 6'(p1);
        bus.retire_cnt   = 2'(rc);
        bus.flush        = fl;
    endtask

    // Inputs are driven and outputs sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        drive(0, 2'b00, 0, 0, 0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 2'b00, 0, 0, 0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.free_cnt !== 6'(D)) begin n_bad++;
            $display("FAIL reset_free_cnt: got %0d want %0d", bus.free_cnt, D); end
        n_cmp++; if (bus.alloc_ready !== 1'b1) begin n_bad++;
            $display("FAIL reset_alloc_ready: got %b want 1", bus.alloc_ready); end
        n_cmp++; if (bus.alloc_preg[0] !== 6'd32 || bus.alloc_preg[1] !== 6'd33) begin n_bad++;
            $display("FAIL reset_alloc_preg: got (%0d,%0d) want (32,33)",
                     bus.alloc_preg[0], bus.alloc_preg[1]); end
        n_cmp++; if (bus.overflow_err !== 1'b0) begin n_bad++;
            $display("FAIL reset_overflow_err: got %b want 0", bus.overflow_err); end
    endtask

    task automatic test_drain_and_wrap();
        int e0, e1;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(2, 2'b00, 0, 0, 0, 1'b0);
            exp_q.push_back(32 + 2 * i);
            exp_q.push_back(33 + 2 * i);
            e0 = exp_q.pop_front();
            e1 = exp_q.pop_front();
            n_cmp++; if (bus.alloc_preg[0] !== 6'(e0) || bus.alloc_preg[1] !== 6'(e1)) begin n_bad++;
                $display("FAIL drain_pair[%0d]: got (%0d,%0d) want (%0d,%0d)", i,
                         bus.alloc_preg[0], bus.alloc_preg[1], e0, e1); end
            tick();
            if (i == 14) begin
                n_cmp++; if (bus.free_cnt !== 6'd2) begin n_bad++;
                    $display("FAIL drain_free_cnt_15: got %0d want 2", bus.free_cnt); end
            end
        end
        n_cmp++; if (bus.free_cnt !== 6'd0 || bus.alloc_ready !== 1'b0) begin n_bad++;
            $display("FAIL drain_empty: got cnt=%0d rdy=%b want cnt=0 rdy=0",
                     bus.free_cnt, bus.alloc_ready); end
        // Retire the owners while returning their old mappings.
        drive(0, 2'b10, 0, 5, 1, 1'b0);
        tick();
        n_cmp++; if (bus.free_cnt !== 6'd1 || bus.alloc_ready !== 1'b0) begin n_bad++;
            $display("FAIL free_one: got cnt=%0d rdy=%b want cnt=1 rdy=0",
                     bus.free_cnt, bus.alloc_ready); end
        drive(0, 2'b01, 7, 0, 1, 1'b0);
        tick();
        n_cmp++; if (bus.alloc_ready !== 1'b1 || bus.alloc_preg[0] !== 6'd5 ||
                     bus.alloc_preg[1] !== 6'd7) begin n_bad++;
            $display("FAIL free_wrap: got rdy=%b (%0d,%0d) want rdy=1 (5,7)",
                     bus.alloc_ready, bus.alloc_preg[0], bus.alloc_preg[1]); end
        n_cmp++; if (bus.overflow_err !== 1'b0) begin n_bad++;
            $display("FAIL free_wrap_err: got %b want 0", bus.overflow_err); end
        // Reset mid-operation discards this cycle's requests.
        rst = 1'b1;
        drive(2, 2'b11, 1, 2, 1, 1'b1);
        tick();
        rst = 1'b0;
        n_cmp++; if (bus.free_cnt !== 6'(D) || bus.alloc_preg[0] !== 6'd32 ||
                     bus.alloc_preg[1] !== 6'd33) begin n_bad++;
            $display("FAIL midop_reset: got cnt=%0d (%0d,%0d) want cnt=32 (32,33)",
                     bus.free_cnt, bus.alloc_preg[0], bus.alloc_preg[1]); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(2, 2'b00, 0, 0, 0, 1'b0);
        tick();
        drive(1, 2'b00, 0, 0, 0, 1'b0);
        n_cmp++; if (bus.alloc_preg[0] !== 6'd34) begin n_bad++;
            $display("FAIL flush_third_alloc: got %0d want 34", bus.alloc_preg[0]); end
        tick();
        drive(0, 2'b00, 0, 0, 1, 1'b0);
        tick();
        drive(0, 2'b00, 0, 0, 0, 1'b1);
        tick();
        n_cmp++; if (bus.alloc_preg[0] !== 6'd33 || bus.alloc_preg[1] !== 6'd34 ||
                     bus.free_cnt !== 6'd31) begin n_bad++;
            $display("FAIL flush_rewind: got (%0d,%0d) cnt=%0d want (33,34) cnt=31",
                     bus.alloc_preg[0], bus.alloc_preg[1], bus.free_cnt); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        drive(2, 2'b00, 0, 0, 0, 1'b0);
        tick();
        drive(2, 2'b01, 3, 0, 1, 1'b1);
        tick();
        n_cmp++; if (bus.free_cnt !== 6'd32 || bus.alloc_preg[0] !== 6'd33) begin n_bad++;
            $display("FAIL same_cycle_ptrs: got cnt=%0d lane0=%0d want cnt=32 lane0=33",
                     bus.free_cnt, bus.alloc_preg[0]); end
        for (int i = 0; i < 15; i++) begin
            drive(2, 2'b00, 0, 0, 0, 1'b0);
            tick();
        end
        n_cmp++; if (bus.alloc_preg[0] !== 6'd63 || bus.alloc_preg[1] !== 6'd3 ||
                     bus.free_cnt !== 6'd2) begin n_bad++;
            $display("FAIL same_cycle_stored: got (%0d,%0d) cnt=%0d want (63,3) cnt=2",
                     bus.alloc_preg[0], bus.alloc_preg[1], bus.free_cnt); end
        n_cmp++; if (bus.overflow_err !== 1'b0) begin n_bad++;
            $display("FAIL same_cycle_err: got %b want 0", bus.overflow_err); end
    endtask

    task automatic test_overflow();
        do_reset();
        drive(0, 2'b01, 10, 0, 0, 1'b0);
        tick();
        n_cmp++; if (bus.overflow_err !== 1'b1) begin n_bad++;
            $display("FAIL overflow_set: got %b want 1", bus.overflow_err); end
        n_cmp++; if (bus.free_cnt !== 6'(D) || bus.alloc_preg[0] !== 6'd32) begin n_bad++;
            $display("FAIL overflow_dropped: got cnt=%0d lane0=%0d want cnt=32 lane0=32",
                     bus.free_cnt, bus.alloc_preg[0]); end
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if (bus.overflow_err !== 1'b1) begin n_bad++;
            $display("FAIL overflow_sticky: got %b want 1", bus.overflow_err); end
        do_reset();
        n_cmp++; if (bus.overflow_err !== 1'b0) begin n_bad++;
            $display("FAIL overflow_cleared: got %b want 0", bus.overflow_err); end
    endtask

    task automatic test_random();
        int    mq[$];
        spec_t sq[$];
        int    arch_rat[NUM_AREGS];
        int    spec_rat[NUM_AREGS];
        int    seen[NUM_PREGS];
        int    unique_cnt;
        for (int i = 0; i < D; i++) mq.push_back(NUM_AREGS + i);
        for (int i = 0; i < NUM_AREGS; i++) arch_rat[i] = i;
        spec_rat = arch_rat;
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            int         ac, rc, p0, p1, e;
            int         freed[2];
            logic       fl;
            logic [1:0] fv;
            bit         ready_exp, fire;
            spec_t      s;
            ready_exp = mq.size() >= 2;
            n_cmp++; if (bus.alloc_ready !== ready_exp || bus.free_cnt !== 6'(mq.size())) begin
                n_bad++;
                $display("FAIL rand_status[%0d]: got rdy=%b cnt=%0d want rdy=%b cnt=%0d", cyc,
                         bus.alloc_ready, bus.free_cnt, ready_exp, mq.size()); end
            ac = $urandom_range(0, 2);
            fl = ($urandom_range(0, 11) == 0);
            rc = $urandom_range(0, (sq.size() < 2) ? sq.size() : 2);
            freed = '{0, 0};
            for (int j = 0; j < rc; j++) begin
                s = sq.pop_front();
                arch_rat[s.areg] = s.newp;
                freed[j] = s.oldp;
            end
            p0 = $urandom_range(0, 63);
            p1 = $urandom_range(0, 63);
            fv = 2'b00;
            if (rc == 2) begin
                fv = 2'b11; p0 = freed[0]; p1 = freed[1];
            end else if (rc == 1) begin
                if ($urandom_range(0, 1) == 1) begin fv = 2'b10; p1 = freed[0]; end
                else begin fv = 2'b01; p0 = freed[0]; end
            end
            drive(ac, fv, p0, p1, rc, fl);
            fire = ready_exp && ac != 0 && !fl;
            if (fire) begin
                for (int k = 0; k < ac; k++) begin
                    e = mq.pop_front();
                    n_cmp++; if (bus.alloc_preg[k] !== 6'(e)) begin n_bad++;
                        $display("FAIL rand_alloc[%0d] lane %0d: got %0d want %0d", cyc, k,
                                 bus.alloc_preg[k], e); end
                    s.areg = $urandom_range(0, NUM_AREGS - 1);
                    s.newp = e;
                    s.oldp = spec_rat[s.areg];
                    spec_rat[s.areg] = e;
                    sq.push_back(s);
                end
            end
            for (int j = 0; j < rc; j++) mq.push_back(freed[j]);
            if (fl) begin
                for (int j = sq.size() - 1; j >= 0; j--) mq.push_front(sq[j].newp);
                sq.delete();
                spec_rat = arch_rat;
            end
            tick();
        end
        foreach (seen[p]) seen[p] = 0;
        foreach (arch_rat[i]) seen[arch_rat[i]]++;
        foreach (sq[i]) seen[sq[i].newp]++;
        foreach (mq[i]) seen[mq[i]]++;
        unique_cnt = 0;
        foreach (seen[p]) if (seen[p] == 1) unique_cnt++;
        n_cmp++; if (unique_cnt != NUM_PREGS || (NUM_AREGS + sq.size() + mq.size()) != NUM_PREGS) begin
            n_bad++;
            $display("FAIL rand_ownership: got unique=%0d total=%0d want %0d", unique_cnt,
                     NUM_AREGS + sq.size() + mq.size(), NUM_PREGS); end
        n_cmp++; if (bus.overflow_err !== 1'b0) begin n_bad++;
            $display("FAIL rand_overflow_err: got %b want 0", bus.overflow_err); end
    endtask

    initial begin
        drive(0, 2'b00, 0, 0, 0, 1'b0);
        @(negedge clk);
        test_reset();
        test_drain_and_wrap();
        test_flush();
        test_same_cycle();
        test_overflow();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
